// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

   // Sequencer state: normal issue or multi-cycle op occupying EX
   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_e;

   // Which rule is shaping the control outputs this cycle
   typedef enum logic [1:0] {
      NONE     = 2'd0,
      BRANCH   = 2'd1,
      MD       = 2'd2,
      LOAD_USE = 2'd3
   } hazard_cause_e;

   // Architectural zero register; never a real dependency
   localparam logic [4:0] REG_X0 = 5'd0;

   // True when the instruction in ID reads the register a load in EX writes
   function automatic logic load_use_match(
      input logic [4:0] rs1,
      input logic [4:0] rs2,
      input logic       uses_rs1,
      input logic       uses_rs2,
      input logic [4:0] rd,
      input logic       mem_read
   );
      return mem_read && (rd != REG_X0) &&
             ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Enable-driven saturating event counter; sticks at all-ones.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   // Count enabled cycles, holding once every bit is set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard sequencer: load-use stall, taken-branch flush, multi-cycle EX hold,
// plus saturating stall/flush performance counters.
//
// Control outputs are Mealy: they respond in the same cycle as the inputs
// that raise the hazard. A multi-cycle op is held for MD_LATENCY-1 cycles
// (the detection cycle in RUN plus MD_LATENCY-2 cycles in MD_BUSY), then
// released on the MD_BUSY exit cycle when md_cnt has reached zero.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int MD_LATENCY = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_if_id,
   input  logic [4:0]       rs2_if_id,
   input  logic             uses_rs1_if_id,
   input  logic             uses_rs2_if_id,
   input  logic [4:0]       rd_id_ex,
   input  logic             mem_read_id_ex,
   input  logic             md_op_id_ex,
   input  logic             branch_taken_ex,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_hold,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output hazard_cause_e    cause
);

   // A latency of 1 finishes within the normal EX slot and never stalls
   localparam bit         MD_STALLS = (MD_LATENCY >= 2);
   localparam logic [7:0] MD_RELOAD = MD_STALLS ? 8'(MD_LATENCY - 2) : 8'd0;

   state_e     state, state_next;
   logic [7:0] md_cnt, md_cnt_next;
   logic       load_use;

   assign load_use = load_use_match(rs1_if_id, rs2_if_id, uses_rs1_if_id,
                                    uses_rs2_if_id, rd_id_ex, mem_read_id_ex);

   // State, latency counter and registered busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RUN;
         md_cnt  <= 8'd0;
         md_busy <= 1'b0;
      end else begin
         state   <= state_next;
         md_cnt  <= md_cnt_next;
         md_busy <= (state_next == MD_BUSY);
      end
   end

   // Next state and prioritised hazard response
   always_comb begin
      state_next  = state;
      md_cnt_next = md_cnt;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_hold     = 1'b0;
      cause       = NONE;
      case (state)
         RUN: begin
            if (branch_taken_ex) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               cause       = BRANCH;
            end else if (md_op_id_ex && MD_STALLS) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               ex_hold     = 1'b1;
               state_next  = MD_BUSY;
               md_cnt_next = MD_RELOAD;
               cause       = MD;
            end else if (load_use) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               cause       = LOAD_USE;
            end
         end
         MD_BUSY: begin
            if (md_cnt != 8'd0) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               ex_hold     = 1'b1;
               md_cnt_next = md_cnt - 8'd1;
               cause       = MD;
            end else begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (~pc_write),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (if_id_flush),
      .count (flush_count)
   );

endmodule
